vec_cache_sram_rdata_collector: RTL and testbench
=================================================

# vec_cache_sram_rdata_collector

Downstream stage of the two-instance vector-cache SRAM pair: per channel, tracks each issued SRAM read through the fixed SRAM read latency, captures the returning 32-bit word with its tag into a small response FIFO, and presents it on a valid/ready interface. Issue is credit-gated: the collector tells the read scheduler when a channel may issue, so SRAM read data, which cannot be stalled, is never dropped.

## Interface
- RD_LAT, 2, SRAM read latency in cycles from read_vld to rd_data valid (≥1)
- FIFO_DEPTH, 4, response FIFO entries per channel (power of two, ≥2)
- TAG_W, 6, width of the per-read tag returned with data
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- read_vld_0 / read_vld_1  in  1  read issued to SRAM instance 0 / 1 this cycle
- rd_tag_0 / rd_tag_1  in  TAG_W  tag accompanying the read
- rd_data_0 / rd_data_1  in  32  SRAM read data, valid RD_LAT cycles after read_vld
- issue_rdy_0 / issue_rdy_1  out  1  channel has a free credit; reset 1
- rsp_vld_0 / rsp_vld_1  out  1  response valid; reset 0
- rsp_data_0 / rsp_data_1  out  32  response data; reset 0
- rsp_tag_0 / rsp_tag_1  out  TAG_W  response tag; reset 0
- rsp_rdy_0 / rsp_rdy_1  in  1  consumer accepts response
- ovf_err  out  1  sticky: a read was issued with issue_rdy low; reset 0

## Operation
- Two independent, identical channels; no cross-channel interaction except the shared ovf_err.
- Per channel, an RD_LAT-deep shift pipe carries {vld, tag}; stage 0 loads read_vld/rd_tag each cycle.
- When the pipe's last stage is valid, rd_data is pushed with that tag into the channel FIFO that cycle.
- Credit counter `outstanding` (width clog2(FIFO_DEPTH+1)) = reads in the pipe + FIFO occupancy.
  - +1 on read_vld, −1 on response handshake (rsp_vld & rsp_rdy); both in the same cycle leave it unchanged.
  - issue_rdy = (outstanding < FIFO_DEPTH), combinational from the register only, with no path from read_vld.
- read_vld while issue_rdy is low: the read is still tracked, ovf_err is set and held until reset, and the counter saturates at FIFO_DEPTH. A push into a full FIFO is dropped and does not overwrite any entry.
- Responses leave strictly in issue order per channel. Tags are opaque and not checked.
- rsp_data/rsp_tag hold stable while rsp_vld is high and rsp_rdy is low.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with natural wrap. Full/empty come from MSB comparison.
- Reset mid-operation clears the pipe, the FIFOs and the counters. SRAM data already in flight is discarded, and issue_rdy returns to 1 on the first cycle after reset release.

## Timing
- read_vld at cycle T → data captured at T+RD_LAT → rsp_vld at T+RD_LAT+1, which is the registered FIFO output.
- Back-to-back reads with rsp_rdy held high: one response per cycle, and issue_rdy never drops.
- rsp_rdy held low: after FIFO_DEPTH issues issue_rdy falls. It rises the cycle after the first pop.
- Pop and push on the same cycle with the FIFO full are both allowed, because the pop frees the slot first.

## Configuration
- VEC_CACHE_RDATA_BYPASS_EN defined: when the channel FIFO is empty and rsp_rdy is high, landing data drives rsp_vld/rsp_data/rsp_tag combinationally at T+RD_LAT and is not written to the FIFO. The FIFO is used only when the bypass cannot complete.
- VEC_CACHE_RDATA_BYPASS_EN undefined: every response goes through the FIFO, with fixed latency RD_LAT+1.
- Credit accounting is identical in both builds.

## Structure
- vector_cache_pkg holds:
  - the response struct vec_rdata_rsp_t {tag, data}
  - the default constants VEC_SRAM_RD_LAT and VEC_RDATA_FIFO_DEPTH
- Sub-module vec_cache_rdata_fifo: a synchronous FIFO with push/pop, full/empty and registered head output. It is instantiated once per channel.
- The latency pipe, credit counter and bypass mux live in the top module.

## Test plan
- Single read: read_vld_0 with tag 0x05 at T, rd_data_0=0xDEADBEEF at T+2 → rsp_vld_0 with data 0xDEADBEEF and tag 0x05 at T+3. With bypass compiled in, the response appears at T+2.
- Backpressure: rsp_rdy_0=0 and 4 reads issued → issue_rdy_0 falls after the 4th read. Raising rsp_rdy_0 returns tags in order 0,1,2,3, and issue_rdy_0 rises the cycle after the first pop.
- Streaming: one read per cycle for 20 cycles with rsp_rdy high → 20 in-order responses, issue_rdy never low, ovf_err=0.
- Channel independence: channel 1 stalled full while channel 0 streams → channel 0 throughput is unaffected and channel 1 data is intact.
- Overflow: read_vld_1 issued while issue_rdy_1=0 → ovf_err=1 and held until reset, and existing FIFO entries are not corrupted.
- Reset mid-flight: assert rst_n low with 2 reads in the pipe → all rsp_vld=0, issue_rdy=1, and no stale response appears after reset release.

Source files
------------

// File: rtl/vector_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_cache_pkg
// Description : Shared constants and the response record for the vector-cache
//               SRAM read-data collector.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_cache_pkg;

  localparam int VEC_SRAM_RD_LAT      = 2;
  localparam int VEC_RDATA_FIFO_DEPTH = 4;
  localparam int VEC_RDATA_TAG_W      = 6;

  // One response as presented to the consumer
  typedef struct packed {
    logic [VEC_RDATA_TAG_W-1:0] tag;
    logic [31:0]                data;
  } vec_rdata_rsp_t;

endpackage
`default_nettype wire

// File: rtl/vec_cache_sram_rdata_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : vec_cache_sram_rdata_collector_if
// Description : Per-channel bundle: SRAM read issue/return, credit back to the
//               read scheduler and the valid/ready response stream.
//               master = scheduler/SRAM/consumer side, slave = collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface vec_cache_sram_rdata_collector_if
  import vector_cache_pkg::*;
#(
  parameter int TAG_W = VEC_RDATA_TAG_W
);
  logic             read_vld;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             issue_rdy;
  logic             rsp_vld;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_rdy;

  modport master (
    output read_vld, rd_tag, rd_data, rsp_rdy,
    input  issue_rdy, rsp_vld, rsp_data, rsp_tag
  );

  modport slave (
    input  read_vld, rd_tag, rd_data, rsp_rdy,
    output issue_rdy, rsp_vld, rsp_data, rsp_tag
  );
endinterface
`default_nettype wire

// File: rtl/vec_cache_rdata_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vec_cache_rdata_fifo
// Description : Small synchronous FIFO with registered head. Pointers carry one
//               extra wrap bit; full/empty come from comparing it. The caller
//               only issues legal pushes/pops.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_cache_rdata_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 38
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_push,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic          i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [DW-1:0]      o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage; cleared so the head reads zero straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end
endmodule
`default_nettype wire

// File: rtl/vec_cache_sram_rdata_collector.sv
`default_nettype none
// ============================================================================
// Module      : vec_cache_sram_rdata_collector
// Description : Two independent channels. Each tracks SRAM reads through a
//               RD_LAT-deep {vld,tag} pipe, captures landing data into a
//               response FIFO, and grants issue credits so un-stallable SRAM
//               data always has a slot. Shared sticky overflow flag.
//               Option macro VEC_CACHE_RDATA_BYPASS_EN: landing data skips the
//               FIFO when it is empty and the consumer is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_cache_sram_rdata_collector
  import vector_cache_pkg::*;
#(
  parameter int RD_LAT     = VEC_SRAM_RD_LAT,
  parameter int FIFO_DEPTH = VEC_RDATA_FIFO_DEPTH,
  parameter int TAG_W      = VEC_RDATA_TAG_W
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  vec_cache_sram_rdata_collector_if.slave ch0,
  vec_cache_sram_rdata_collector_if.slave ch1,
  output logic                            o_ovf_err
);
  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam int            DW      = TAG_W + 32;
  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  logic [1:0]       w_read_vld, w_rsp_rdy, w_issue_rdy, w_rsp_vld, w_ovf;
  logic [TAG_W-1:0] w_rd_tag  [2];
  logic [TAG_W-1:0] w_rsp_tag [2];
  logic [31:0]      w_rd_data [2];
  logic [31:0]      w_rsp_data[2];
  logic             r_ovf_err;

  assign w_read_vld = {ch1.read_vld, ch0.read_vld};
  assign w_rsp_rdy  = {ch1.rsp_rdy,  ch0.rsp_rdy};
  assign w_rd_tag[0]  = ch0.rd_tag;
  assign w_rd_tag[1]  = ch1.rd_tag;
  assign w_rd_data[0] = ch0.rd_data;
  assign w_rd_data[1] = ch1.rd_data;

  assign ch0.issue_rdy = w_issue_rdy[0];
  assign ch0.rsp_vld   = w_rsp_vld[0];
  assign ch0.rsp_data  = w_rsp_data[0];
  assign ch0.rsp_tag   = w_rsp_tag[0];
  assign ch1.issue_rdy = w_issue_rdy[1];
  assign ch1.rsp_vld   = w_rsp_vld[1];
  assign ch1.rsp_data  = w_rsp_data[1];
  assign ch1.rsp_tag   = w_rsp_tag[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [TAG_W-1:0]  r_pipe_tag [RD_LAT];
    logic [CW-1:0]     r_outstanding;
    logic              w_land, w_byp, w_push, w_pop, w_hs, w_full, w_empty;
    logic [DW-1:0]     w_head;

    // Latency pipe: stage RD_LAT-1 is valid exactly when the SRAM data lands
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pipe_vld <= '0;
        for (int s = 0; s < RD_LAT; s++) r_pipe_tag[s] <= '0;
      end else begin
        r_pipe_vld[0] <= w_read_vld[c];
        r_pipe_tag[0] <= w_rd_tag[c];
        for (int s = 1; s < RD_LAT; s++) begin
          r_pipe_vld[s] <= r_pipe_vld[s-1];
          r_pipe_tag[s] <= r_pipe_tag[s-1];
        end
      end
    end

    assign w_land = r_pipe_vld[RD_LAT-1];

`ifdef VEC_CACHE_RDATA_BYPASS_EN
    assign w_byp = w_land & w_empty & w_rsp_rdy[c];
`else
    assign w_byp = 1'b0;
`endif

    // Pop frees the slot first, so a full FIFO can take a push on a pop cycle
    assign w_pop  = w_rsp_rdy[c] & ~w_empty;
    assign w_push = w_land & ~w_byp & (~w_full | w_pop);
    assign w_hs   = w_rsp_vld[c] & w_rsp_rdy[c];

    vec_cache_rdata_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata ({r_pipe_tag[RD_LAT-1], w_rd_data[c]}),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
    );

    assign w_rsp_vld[c]  = ~w_empty | w_byp;
    assign w_rsp_data[c] = ~w_empty ? w_head[31:0] :
                           (w_byp ? w_rd_data[c] : 32'd0);
    assign w_rsp_tag[c]  = ~w_empty ? w_head[DW-1:32] :
                           (w_byp ? r_pipe_tag[RD_LAT-1] : '0);

    // Credits = reads in flight + FIFO occupancy; saturate rather than wrap
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_outstanding <= '0;
      end else if (w_read_vld[c] && !w_hs) begin
        if (r_outstanding != C_DEPTH) r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_read_vld[c] && w_hs && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
    end

    assign w_issue_rdy[c] = (r_outstanding < C_DEPTH);
    assign w_ovf[c]       = w_read_vld[c] & ~w_issue_rdy[c];
  end

  // Sticky overflow: any channel issuing without a credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf_err <= 1'b0;
    else if (|w_ovf) r_ovf_err <= 1'b1;
  end

  assign o_ovf_err = r_ovf_err;
endmodule
`default_nettype wire

// File: tb/tb_vec_cache_sram_rdata_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_cache_sram_rdata_collector
// Description : Self-checking bench. The reference model keeps, per channel, a
//               queue of issued reads in issue order with the cycle their data
//               lands; a response is due the cycle after landing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_cache_sram_rdata_collector;
  import vector_cache_pkg::*;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ovf_err;

  always #5 clk = ~clk;

  vec_cache_sram_rdata_collector_if #(.TAG_W(TAG_W)) u_ch0_if ();
  vec_cache_sram_rdata_collector_if #(.TAG_W(TAG_W)) u_ch1_if ();

  vec_cache_sram_rdata_collector #(
    .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch0(u_ch0_if), .ch1(u_ch1_if), .o_ovf_err(ovf_err)
  );

  typedef struct { vec_rdata_rsp_t rsp; int land; } ent_t;

  ent_t        mq [2][$];
  int          mo [2];
  logic        movf;
  int          now;
  logic [31:0] dsd [2][RD_LAT];
  logic        dsv [2][RD_LAT];

  logic             e_vld[2], e_rdy[2], o_vld[2], o_rdy[2], e_ovf, o_ovf;
  logic [31:0]      e_data[2], o_data[2];
  logic [TAG_W-1:0] e_tag[2], o_tag[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      mq[c].delete();
      mo[c] = 0;
      for (int s = 0; s < RD_LAT; s++) dsv[c][s] = 1'b0;
    end
    movf = 1'b0;
  endtask

  // One clock: drive inputs, capture observed/expected, advance the model.
  task automatic step(input logic rv0, input logic rr0, input logic [TAG_W-1:0] tg0,
                      input logic [31:0] d0, input logic rv1, input logic rr1,
                      input logic [TAG_W-1:0] tg1, input logic [31:0] d1);
    logic rv[2], rr[2], pop;
    logic [TAG_W-1:0] tg[2];
    logic [31:0] d[2];
    int occ;
    ent_t ent;
    rv[0] = rv0; rr[0] = rr0; tg[0] = tg0; d[0] = d0;
    rv[1] = rv1; rr[1] = rr1; tg[1] = tg1; d[1] = d1;
    u_ch0_if.read_vld = rv0; u_ch0_if.rd_tag = tg0; u_ch0_if.rsp_rdy = rr0;
    u_ch1_if.read_vld = rv1; u_ch1_if.rd_tag = tg1; u_ch1_if.rsp_rdy = rr1;
    u_ch0_if.rd_data = dsv[0][RD_LAT-1] ? dsd[0][RD_LAT-1] : $urandom;
    u_ch1_if.rd_data = dsv[1][RD_LAT-1] ? dsd[1][RD_LAT-1] : $urandom;
    #1;
    for (int c = 0; c < 2; c++) begin
      e_vld[c]  = (mq[c].size() > 0) && (mq[c][0].land < now);
      e_data[c] = e_vld[c] ? mq[c][0].rsp.data : 32'd0;
      e_tag[c]  = e_vld[c] ? mq[c][0].rsp.tag : '0;
      e_rdy[c]  = (mo[c] < DEPTH);
    end
    e_ovf = movf;
    o_vld[0] = u_ch0_if.rsp_vld; o_data[0] = u_ch0_if.rsp_data;
    o_tag[0] = u_ch0_if.rsp_tag; o_rdy[0]  = u_ch0_if.issue_rdy;
    o_vld[1] = u_ch1_if.rsp_vld; o_data[1] = u_ch1_if.rsp_data;
    o_tag[1] = u_ch1_if.rsp_tag; o_rdy[1]  = u_ch1_if.issue_rdy;
    o_ovf = ovf_err;
    for (int c = 0; c < 2; c++) begin
      pop = e_vld[c] && rr[c];
      occ = 0;
      foreach (mq[c][k]) if (mq[c][k].land < now) occ++;
      for (int k = 0; k < mq[c].size(); k++) begin
        if (mq[c][k].land == now) begin
          if (occ - int'(pop) >= DEPTH) mq[c].delete(k);
          break;
        end
      end
      if (pop) void'(mq[c].pop_front());
      if (rv[c]) begin
        if (!e_rdy[c]) movf = 1'b1;
        ent.rsp.tag = tg[c]; ent.rsp.data = d[c]; ent.land = now + RD_LAT;
        mq[c].push_back(ent);
      end
      if (rv[c] && !pop)      mo[c] = (mo[c] + 1 > DEPTH) ? DEPTH : mo[c] + 1;
      else if (!rv[c] && pop) mo[c] = (mo[c] > 0) ? mo[c] - 1 : 0;
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      for (int s = RD_LAT - 1; s > 0; s--) begin
        dsd[c][s] = dsd[c][s-1]; dsv[c][s] = dsv[c][s-1];
      end
      dsd[c][0] = d[c]; dsv[c][0] = rv[c];
    end
    now++;
    #1;
  endtask

  task automatic idle(input logic rr0, input logic rr1);
    step(1'b0, rr0, '0, 32'd0, 1'b0, rr1, '0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) rst_n = 1'b1;
      idle(1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
        n_tests++;
        if ({o_vld[c], o_data[c], o_tag[c], o_rdy[c]} !== {1'b0, 32'd0, 6'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL reset ch%0d t=%0d: got vld=%b data=%h tag=%h rdy=%b, want 0/0/0/1",
                   c, now, o_vld[c], o_data[c], o_tag[c], o_rdy[c]);
        end
      end
      n_tests++;
      if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_ovf); end
    end
  endtask

  task automatic test_single();
    logic seen = 1'b0;
    step(1'b1, 1'b1, 6'h05, 32'hDEADBEEF, 1'b0, 1'b1, '0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      idle(1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
        n_tests++;
        if ({o_vld[c], o_data[c], o_tag[c]} !== {e_vld[c], e_data[c], e_tag[c]}) begin
          n_fail++;
          $display("FAIL single_rsp ch%0d t=%0d: got %b/%h/%h want %b/%h/%h", c, now,
                   o_vld[c], o_data[c], o_tag[c], e_vld[c], e_data[c], e_tag[c]);
        end
      end
      // the response must sit exactly RD_LAT+1 cycles after issue
      if (i == RD_LAT + 1) begin
        n_tests++;
        if ({o_vld[0], o_data[0], o_tag[0]} !== {1'b1, 32'hDEADBEEF, 6'h05}) begin
          n_fail++;
          $display("FAIL single_latency: got %b/%h/%h want 1/deadbeef/05", o_vld[0], o_data[0], o_tag[0]);
        end
      end
      if (o_vld[0] === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL single_seen: got %b want 1", seen); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) begin
      logic rv = (i < 4);
      logic rr = (i >= 9);
      step(rv, rr, TAG_W'(i), $urandom, 1'b0, 1'b1, '0, 32'd0);
      n_tests++;
      if ({o_vld[0], o_data[0], o_tag[0]} !== {e_vld[0], e_data[0], e_tag[0]}) begin
        n_fail++;
        $display("FAIL bp_rsp t=%0d: got %b/%h/%h want %b/%h/%h", now,
                 o_vld[0], o_data[0], o_tag[0], e_vld[0], e_data[0], e_tag[0]);
      end
      n_tests++;
      if (o_rdy[0] !== e_rdy[0]) begin
        n_fail++; $display("FAIL bp_issue_rdy t=%0d: got %b want %b", now, o_rdy[0], e_rdy[0]);
      end
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 26; i++) begin
      logic rv = (i < 20);
      step(rv, 1'b1, TAG_W'($urandom), $urandom, rv, 1'b1, TAG_W'($urandom), $urandom);
      for (int c = 0; c < 2; c++) begin
        n_tests++;
        if ({o_vld[c], o_data[c], o_tag[c], o_rdy[c]} !== {e_vld[c], e_data[c], e_tag[c], 1'b1}) begin
          n_fail++;
          $display("FAIL stream ch%0d t=%0d: got %b/%h/%h rdy=%b want %b/%h/%h rdy=1", c, now,
                   o_vld[c], o_data[c], o_tag[c], o_rdy[c], e_vld[c], e_data[c], e_tag[c]);
        end
      end
      n_tests++;
      if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL stream_ovf: got %b want 0", o_ovf); end
    end
  endtask

  task automatic test_independence();
    for (int i = 0; i < 24; i++) begin
      logic rv0 = (i < 16);
      logic rv1 = (i < 4);
      logic rr1 = (i >= 18);
      step(rv0, 1'b1, TAG_W'($urandom), $urandom, rv1, rr1, TAG_W'(i + 8), $urandom);
      for (int c = 0; c < 2; c++) begin
        n_tests++;
        if ({o_vld[c], o_data[c], o_tag[c], o_rdy[c]} !== {e_vld[c], e_data[c], e_tag[c], e_rdy[c]}) begin
          n_fail++;
          $display("FAIL indep ch%0d t=%0d: got %b/%h/%h rdy=%b want %b/%h/%h rdy=%b", c, now,
                   o_vld[c], o_data[c], o_tag[c], o_rdy[c], e_vld[c], e_data[c], e_tag[c], e_rdy[c]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) begin
      logic rv1 = (i < 4) || (i == 7);
      logic rr1 = (i >= 11);
      step(1'b0, 1'b1, '0, 32'd0, rv1, rr1, TAG_W'(i + 32), $urandom);
      n_tests++;
      if ({o_vld[1], o_data[1], o_tag[1], o_rdy[1]} !== {e_vld[1], e_data[1], e_tag[1], e_rdy[1]}) begin
        n_fail++;
        $display("FAIL ovf_rsp t=%0d: got %b/%h/%h rdy=%b want %b/%h/%h rdy=%b", now,
                 o_vld[1], o_data[1], o_tag[1], o_rdy[1], e_vld[1], e_data[1], e_tag[1], e_rdy[1]);
      end
      n_tests++;
      if (o_ovf !== e_ovf) begin n_fail++; $display("FAIL ovf_flag t=%0d: got %b want %b", now, o_ovf, e_ovf); end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 1'b1, 6'h11, $urandom, 1'b1, 1'b1, 6'h22, $urandom);
    step(1'b1, 1'b1, 6'h12, $urandom, 1'b1, 1'b1, 6'h23, $urandom);
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst_n = 1'b1;
      idle(1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
        n_tests++;
        if ({o_vld[c], o_rdy[c]} !== {e_vld[c], e_rdy[c]}) begin
          n_fail++;
          $display("FAIL midreset ch%0d t=%0d: got vld=%b rdy=%b want vld=%b rdy=%b",
                   c, now, o_vld[c], o_rdy[c], e_vld[c], e_rdy[c]);
        end
      end
      n_tests++;
      if (o_ovf !== e_ovf) begin n_fail++; $display("FAIL midreset_ovf: got %b want %b", o_ovf, e_ovf); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic rv0 = (i < 380) && ($urandom_range(0, 2) != 0) && (mo[0] < DEPTH);
      logic rv1 = (i < 380) && ($urandom_range(0, 1) != 0) && (mo[1] < DEPTH);
      logic rr0 = (i >= 380) || ($urandom_range(0, 3) != 0);
      logic rr1 = (i >= 380) || ($urandom_range(0, 1) != 0);
      step(rv0, rr0, TAG_W'($urandom), $urandom, rv1, rr1, TAG_W'($urandom), $urandom);
      for (int c = 0; c < 2; c++) begin
        n_tests++;
        if ({o_vld[c], o_data[c], o_tag[c], o_rdy[c]} !== {e_vld[c], e_data[c], e_tag[c], e_rdy[c]}) begin
          n_fail++;
          $display("FAIL random ch%0d t=%0d: got %b/%h/%h rdy=%b want %b/%h/%h rdy=%b", c, now,
                   o_vld[c], o_data[c], o_tag[c], o_rdy[c], e_vld[c], e_data[c], e_tag[c], e_rdy[c]);
        end
      end
      n_tests++;
      if (o_ovf !== e_ovf) begin n_fail++; $display("FAIL random_ovf t=%0d: got %b want %b", now, o_ovf, e_ovf); end
    end
  endtask

  initial begin
    now = 0;
    u_ch0_if.read_vld = 1'b0; u_ch0_if.rd_tag = '0; u_ch0_if.rd_data = '0; u_ch0_if.rsp_rdy = 1'b0;
    u_ch1_if.read_vld = 1'b0; u_ch1_if.rd_tag = '0; u_ch1_if.rd_data = '0; u_ch1_if.rsp_rdy = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_independence();
    test_overflow();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
